// File: rtl/jpeg_raster_wr.sv
// Reorders 16x16-block decoder output into raster frame-buffer writes through a
// single output register stage; addresses come from running bases, not a multiplier.
module jpeg_raster_wr #(
    parameter int BLK_W  = 61,
    parameter int BLK_H  = 61,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ai_we,
    output logic              ao_next,
    input  logic              ai_begin,
    input  logic              ai_end,
    input  logic [31:0]       ai_data,
    input  logic              ai_type,
    output logic              bo_we,
    input  logic              bi_next,
    output logic [ADDR_W-1:0] bo_addr,
    output logic [23:0]       bo_data,
    output logic              bo_type,
    output logic              frame_done,
    output logic              err_ovf
);
    localparam int BXW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int BYW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam logic [BXW-1:0]    BX_LAST   = BXW'(BLK_W - 1);
    localparam logic [BYW-1:0]    BY_LAST   = BYW'(BLK_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(16 * BLK_W);
    localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(256 * BLK_W);
    localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(16);

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t            state;
    logic [7:0]        pix;
    logic [BXW-1:0]    bx;
    logic [BYW-1:0]    by;
    logic              full;
    logic [ADDR_W-1:0] band_base, blk_base, row_off;
    logic              bo_last;

    logic [7:0]        cur_pix, nxt_pix;
    logic [BXW-1:0]    cur_bx, nxt_bx;
    logic [BYW-1:0]    cur_by, nxt_by;
    logic              cur_full, nxt_full;
    logic [ADDR_W-1:0] cur_band, cur_blk, cur_row_off;
    logic [ADDR_W-1:0] nxt_band, nxt_blk, nxt_row_off;
    logic [ADDR_W-1:0] pix_addr;
    logic              accept, do_write;
    logic              unused_lsb;

    assign unused_lsb = ^ai_data[7:0];

    // A begin pixel is placed at position 0 regardless of where the counters stand.
    always_comb begin
        cur_pix     = ai_begin ? 8'd0 : pix;
        cur_bx      = ai_begin ? '0 : bx;
        cur_by      = ai_begin ? '0 : by;
        cur_full    = ai_begin ? 1'b0 : full;
        cur_band    = ai_begin ? '0 : band_base;
        cur_blk     = ai_begin ? '0 : blk_base;
        cur_row_off = ai_begin ? '0 : row_off;
        pix_addr    = cur_blk + cur_row_off + ADDR_W'(cur_pix[3:0]);

        nxt_pix     = cur_pix + 8'd1;
        nxt_bx      = cur_bx;
        nxt_by      = cur_by;
        nxt_full    = cur_full;
        nxt_band    = cur_band;
        nxt_blk     = cur_blk;
        nxt_row_off = cur_row_off;
        if (cur_pix[3:0] == 4'hF)
            nxt_row_off = cur_row_off + ROW_STEP;
        if (cur_pix == 8'hFF) begin
            nxt_row_off = '0;
            if (cur_bx != BX_LAST) begin
                nxt_bx  = cur_bx + 1'b1;
                nxt_blk = cur_blk + BLK_STEP;
            end else begin
                nxt_bx = '0;
                if (cur_by != BY_LAST) begin
                    nxt_by   = cur_by + 1'b1;
                    nxt_band = cur_band + BAND_STEP;
                    nxt_blk  = cur_band + BAND_STEP;
                end else begin
                    // Picture complete: any further non-begin pixel is an overflow.
                    nxt_by   = '0;
                    nxt_band = '0;
                    nxt_blk  = '0;
                    nxt_full = 1'b1;
                end
            end
        end
    end

    // Gated on the output register in every state so a begin pixel can never
    // overwrite a write still stalled from the previous frame.
    assign ao_next  = !bo_we | bi_next;
    assign accept   = ai_we & ao_next;
    assign do_write = accept & (ai_begin | (state == RUN & !full));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pix        <= '0;
            bx         <= '0;
            by         <= '0;
            full       <= 1'b0;
            band_base  <= '0;
            blk_base   <= '0;
            row_off    <= '0;
            bo_we      <= 1'b0;
            bo_addr    <= '0;
            bo_data    <= '0;
            bo_type    <= 1'b0;
            bo_last    <= 1'b0;
            frame_done <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            frame_done <= bo_we & bi_next & bo_last;
            if (bi_next)
                bo_we <= 1'b0;
            if (do_write) begin
                bo_we     <= 1'b1;
                bo_addr   <= pix_addr;
                bo_data   <= ai_data[31:8];
                bo_type   <= ai_type;
                bo_last   <= ai_end;
                pix       <= nxt_pix;
                bx        <= nxt_bx;
                by        <= nxt_by;
                full      <= nxt_full;
                band_base <= nxt_band;
                blk_base  <= nxt_blk;
                row_off   <= nxt_row_off;
            end
            if (accept) begin
                case (state)
                    IDLE: if (ai_begin) state <= ai_end ? IDLE : RUN;
                    RUN: begin
                        if (cur_full) begin
                            err_ovf <= 1'b1;
                            state   <= ai_end ? IDLE : DROP;
                        end else if (ai_end) begin
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (ai_begin)    state <= ai_end ? IDLE : RUN;
                        else if (ai_end) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jpeg_raster_wr.sv
// Randomized bench for jpeg_raster_wr (2x2 blocks, 32x32 picture) checked against
// an arithmetic block-to-raster model and a write scoreboard.
module tb_jpeg_raster_wr;
    typedef struct {logic [31:0] d; logic t; logic b; logic e;} pix_t;
    typedef struct {logic [9:0] a; logic [23:0] d; logic t; logic l;} wr_t;

    logic       clk = 0;
    logic       rst = 0;
    logic       ai_we = 0, ai_begin = 0, ai_end = 0, ai_type = 0;
    logic [31:0] ai_data = '0;
    logic       bi_next = 1;
    logic       ao_next, bo_we, bo_type, frame_done, err_ovf;
    logic [9:0] bo_addr;
    logic [23:0] bo_data;

    jpeg_raster_wr #(.BLK_W(2), .BLK_H(2), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .ai_we(ai_we), .ao_next(ao_next), .ai_begin(ai_begin),
        .ai_end(ai_end), .ai_data(ai_data), .ai_type(ai_type), .bo_we(bo_we),
        .bi_next(bi_next), .bo_addr(bo_addr), .bo_data(bo_data), .bo_type(bo_type),
        .frame_done(frame_done), .err_ovf(err_ovf));

    always #5 clk = ~clk;

    int   errors = 0, checks = 0;
    int   cyc = 0;
    bit   bp_rand = 0;
    pix_t stim_q[$];
    wr_t  exp_q[$], got_q[$];
    int   got_cyc[$], fd_cyc[$];
    int   m_mode = 0, m_n = 0;
    bit   m_err = 0;

    initial forever begin @(posedge clk); cyc++; end

    initial forever begin
        @(posedge clk); #1;
        bi_next = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: collects completed writes and done pulses; checks stall stability.
    initial begin
        bit        stalled = 0;
        wr_t       held;
        wr_t       w;
        forever begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (bo_we !== 1'b1 || bo_addr !== held.a || bo_data !== held.d || bo_type !== held.t) begin
                    errors++;
                    $display("FAIL stall_hold: got we=%b addr=%0d data=%h type=%b, held addr=%0d data=%h type=%b",
                             bo_we, bo_addr, bo_data, bo_type, held.a, held.d, held.t);
                end
            end
            if (bo_we && bi_next) begin
                w.a = bo_addr; w.d = bo_data; w.t = bo_type; w.l = 0;
                got_q.push_back(w);
                got_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            stalled = rst && bo_we && !bi_next;
            held.a = bo_addr; held.d = bo_data; held.t = bo_type;
        end
    end

    function automatic int ref_addr(int n);
        int b = n / 256, p = n % 256;
        return ((b / 2) * 16 + p / 16) * 32 + (b % 2) * 16 + p % 16;
    endfunction

    function automatic int first_diff();
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d || got_q[i].t !== exp_q[i].t)
                return i;
        return (got_q.size() != exp_q.size()) ? n : -1;
    endfunction

    function automatic int n_last();
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i].l) c++;
        return c;
    endfunction

    task automatic clear_q();
        stim_q.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete(); fd_cyc.delete();
    endtask

    // Frame of n pixels; spec_data selects the R=n[7:0], G=n[9:2] pattern.
    task automatic mk_frame(int n, int beg_at, int end_at, bit spec_data);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            logic [31:0] r = $urandom;
            logic [9:0]  k = 10'(i);
            p.d = spec_data ? {k[7:0], k[9:2], 8'h00, r[7:0]} : r;
            p.t = 1'($urandom_range(0, 1));
            p.b = (i == beg_at);
            p.e = (i == end_at);
            stim_q.push_back(p);
        end
    endtask

    task automatic build_exp();
        wr_t w;
        foreach (stim_q[i]) begin
            pix_t p = stim_q[i];
            bit   emit = 0;
            if (p.b) begin
                m_n = 0; emit = 1; m_mode = p.e ? 0 : 1;
            end else if (m_mode == 1) begin
                if (m_n >= 1024) begin m_err = 1; m_mode = p.e ? 0 : 2; end
                else begin emit = 1; m_mode = p.e ? 0 : 1; end
            end else if (m_mode == 2 && p.e) begin
                m_mode = 0;
            end
            if (emit) begin
                w.a = 10'(ref_addr(m_n)); w.d = p.d[31:8]; w.t = p.t; w.l = p.e;
                exp_q.push_back(w);
                m_n++;
            end
        end
    endtask

    task automatic drive(int from, int upto);
        for (int i = from; i < upto; i++) begin
            bit ok = 0;
            int w = 0;
            ai_we = 1; ai_data = stim_q[i].d; ai_type = stim_q[i].t;
            ai_begin = stim_q[i].b; ai_end = stim_q[i].e;
            while (!ok && w < 200) begin
                @(negedge clk); ok = ao_next;
                @(posedge clk); #1; w++;
            end
            if (!ok) begin
                errors++; checks++;
                $display("FAIL drive_timeout: pixel %0d not accepted in %0d cycles, required <200", i, w);
            end
        end
        ai_we = 0; ai_begin = 0; ai_end = 0;
    endtask

    task automatic drain();
        int w = 0;
        @(negedge clk);
        while (bo_we && w < 300) begin @(negedge clk); w++; end
        if (bo_we) begin
            errors++; checks++;
            $display("FAIL drain_timeout: bo_we=%b after %0d cycles, required 0", bo_we, w);
        end
        bp_rand = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic run_all();
        build_exp();
        drive(0, stim_q.size());
        drain();
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bo_we, bo_addr, bo_data, bo_type, frame_done, err_ovf} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h type=%b done=%b ovf=%b, required all 0",
                     bo_we, bo_addr, bo_data, bo_type, frame_done, err_ovf);
        end
        @(posedge clk); #1; rst = 1;
        @(negedge clk);
        checks++;
        if (ao_next !== 1'b1) begin
            errors++; $display("FAIL reset_ao_next: got %b, required 1", ao_next);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        int fd;
        int spot_n[4] = '{16, 256, 512, 1023};
        int spot_a[4] = '{32, 16, 512, 1023};
        clear_q();
        mk_frame(1024, 0, 1023, 1);
        run_all();
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL frame_seq: first bad write %0d, got %0d writes, required %0d", fd, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [9:0]  k = 10'(spot_n[i]);
            logic [23:0] ed = {k[7:0], k[9:2], 8'h00};
            checks++;
            if (got_q.size() <= spot_n[i] || got_q[spot_n[i]].a !== 10'(spot_a[i]) || got_q[spot_n[i]].d !== ed) begin
                errors++;
                $display("FAIL frame_spot_%0d: got addr=%0d data=%h, required addr=%0d data=%h", spot_n[i],
                         (got_q.size() > spot_n[i]) ? int'(got_q[spot_n[i]].a) : -1,
                         (got_q.size() > spot_n[i]) ? got_q[spot_n[i]].d : 24'hx, spot_a[i], ed);
            end
        end
        checks++;
        if (fd_cyc.size() != 1 || got_cyc.size() != 1024 || fd_cyc[0] != got_cyc[1023] + 1) begin
            errors++;
            $display("FAIL frame_done_timing: got %0d pulses at cyc %0d, required 1 at cyc %0d", fd_cyc.size(),
                     (fd_cyc.size() > 0) ? fd_cyc[0] : -1, (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] + 1 : -1);
        end
        checks++;
        if (err_ovf !== 1'b0) begin errors++; $display("FAIL frame_err: got %b, required 0", err_ovf); end
    endtask

    task automatic test_backpressure();
        int fd;
        clear_q();
        mk_frame(1024, 0, 1023, 1);
        bp_rand = 1;
        run_all();
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL bp_seq: first bad write %0d, got %0d writes, required %0d", fd, got_q.size(), exp_q.size());
        end
        checks++;
        if (fd_cyc.size() != 1 || got_cyc.size() != 1024 || fd_cyc[0] != got_cyc[1023] + 1) begin
            errors++;
            $display("FAIL bp_done: got %0d pulses, required 1 one cycle after last write", fd_cyc.size());
        end
    endtask

    task automatic test_no_begin();
        clear_q();
        mk_frame(2, -1, -1, 0);
        mk_frame(1024, 0, 1023, 0);
        run_all();
        checks++;
        if (first_diff() != -1 || got_q.size() != 1024 || got_q[0].a !== 10'd0 || got_q[0].d !== stim_q[2].d[31:8]) begin
            errors++;
            $display("FAIL no_begin: got %0d writes first addr=%0d, required 1024 writes from addr 0",
                     got_q.size(), (got_q.size() > 0) ? int'(got_q[0].a) : -1);
        end
    endtask

    task automatic test_single();
        clear_q();
        mk_frame(1, 0, 0, 0);
        bp_rand = 1;
        run_all();
        checks++;
        if (got_q.size() != 1 || first_diff() != -1 || fd_cyc.size() != 1 || fd_cyc[0] != got_cyc[0] + 1) begin
            errors++;
            $display("FAIL single_pixel: got %0d writes %0d done pulses, required 1 write at addr 0 and 1 pulse",
                     got_q.size(), fd_cyc.size());
        end
    endtask

    task automatic test_restart();
        clear_q();
        mk_frame(100, 0, -1, 0);
        mk_frame(1024, 0, 1023, 0);
        bp_rand = 1;
        run_all();
        checks++;
        if (first_diff() != -1 || got_q.size() != 1124 || got_q[100].a !== 10'd0) begin
            errors++;
            $display("FAIL restart: got %0d writes, first diff %0d, required 1124 writes restarting at addr 0",
                     got_q.size(), first_diff());
        end
        checks++;
        if (fd_cyc.size() != n_last()) begin
            errors++; $display("FAIL restart_done: got %0d pulses, required %0d", fd_cyc.size(), n_last());
        end
    endtask

    task automatic test_overflow();
        clear_q();
        mk_frame(1025, 0, 1024, 0);
        run_all();
        checks++;
        if (first_diff() != -1 || got_q.size() != 1024) begin
            errors++; $display("FAIL ovf_writes: got %0d writes, required 1024", got_q.size());
        end
        checks++;
        if (err_ovf !== 1'b1 || err_ovf !== m_err) begin
            errors++; $display("FAIL ovf_flag: got %b, required 1", err_ovf);
        end
        checks++;
        if (fd_cyc.size() != 0) begin
            errors++; $display("FAIL ovf_done: got %0d pulses, required 0", fd_cyc.size());
        end
        // Back in IDLE: pixels without begin vanish, the flag stays set across a new frame.
        clear_q();
        mk_frame(3, -1, -1, 0);
        mk_frame(1024, 0, 1023, 0);
        bp_rand = 1;
        run_all();
        checks++;
        if (first_diff() != -1 || got_q.size() != 1024 || err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: got %0d writes err_ovf=%b, required 1024 writes err_ovf=1", got_q.size(), err_ovf);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        mk_frame(1024, 0, 1023, 0);
        bp_rand = 1;
        drive(0, 300);
        rst = 0;
        @(posedge clk); #1; rst = 1;
        bp_rand = 0;
        @(negedge clk);
        checks++;
        if ({bo_we, bo_addr, bo_data, bo_type, frame_done, err_ovf} !== 37'd0 || ao_next !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: we=%b addr=%0d data=%h type=%b done=%b ovf=%b next=%b, required 0s and next=1",
                     bo_we, bo_addr, bo_data, bo_type, frame_done, err_ovf, ao_next);
        end
        @(posedge clk); #1;
        m_mode = 0; m_n = 0; m_err = 0;
        clear_q();
        mk_frame(1024, 0, 1023, 0);
        run_all();
        checks++;
        if (first_diff() != -1 || got_q.size() != 1024 || fd_cyc.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_frame: got %0d writes %0d pulses, required 1024 and 1", got_q.size(), fd_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        mk_frame(1024, 0, 1023, 0);
        mk_frame(1024, 0, 1023, 0);
        bp_rand = 1;
        run_all();
        checks++;
        if (first_diff() != -1 || got_q.size() != 2048) begin
            errors++; $display("FAIL b2b_seq: got %0d writes, required 2048", got_q.size());
        end
        checks++;
        if (fd_cyc.size() != 2 || fd_cyc[0] != got_cyc[1023] + 1 || fd_cyc[1] != got_cyc[2047] + 1) begin
            errors++; $display("FAIL b2b_done: got %0d pulses, required 2 aligned to last writes", fd_cyc.size());
        end
        checks++;
        if (err_ovf !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b, required 0", err_ovf); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_no_begin();
        test_single();
        test_restart();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
